// File: rtl/nn_out_argmax.sv
// Classifier back-end: snapshots ten signed neuron outputs and scans them one per cycle.
// Reports the winning index and value, plus the margin over the runner-up.
module nn_out_argmax #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*W-1:0]   y_flat,
  output logic             busy,
  output logic             done,
  output logic [3:0]       class_idx,
  output logic [W-1:0]     class_val,
  output logic [W-1:0]     margin
);

  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] snap_q [N];
  logic signed [W-1:0] snap_d [N];
  logic signed [W-1:0] best_q, best_d;
  logic signed [W-1:0] second_q, second_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IW-1:0]       class_idx_q, class_idx_d;
  logic [W-1:0]        class_val_q, class_val_d;
  logic [W-1:0]        margin_q, margin_d;
  logic signed [W-1:0] elem;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    best_d      = best_q;
    second_d    = second_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    class_idx_d = class_idx_q;
    class_val_d = class_val_q;
    margin_d    = margin_q;
    elem        = snap_q[ptr_q];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < int'(N); i++) begin
            snap_d[i] = y_flat[i*W +: W];
          end
          best_d   = y_flat[W-1:0];
          second_d = {1'b1, {(W-1){1'b0}}};
          idx_d    = '0;
          ptr_d    = IW'(1);
          busy_d   = 1'b1;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties
        if (elem > best_q) begin
          second_d = best_q;
          best_d   = elem;
          idx_d    = ptr_q;
        end else if (elem > second_q) begin
          second_d = elem;
        end
        ptr_d = ptr_q + IW'(1);
        if (ptr_q == IW'(N-1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        class_idx_d = idx_q;
        class_val_d = best_q;
        // Difference is non-negative and below 2^W, so modular W-bit subtract is exact
        margin_d    = W'(best_q - second_q);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < int'(N); i++) begin
        snap_q[i] <= '0;
      end
      best_q      <= '0;
      second_q    <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      class_idx_q <= '0;
      class_val_q <= '0;
      margin_q    <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      best_q      <= best_d;
      second_q    <= second_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      class_idx_q <= class_idx_d;
      class_val_q <= class_val_d;
      margin_q    <= margin_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign class_idx = class_idx_q;
  assign class_val = class_val_q;
  assign margin    = margin_q;

endmodule

// File: tb/tb_nn_out_argmax.sv
// Directed bench for nn_out_argmax: vector table plus busy-gating, reset and back-to-back sequences.
module tb_nn_out_argmax;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [79:0] y_flat;
  logic        busy, done;
  logic [3:0]  class_idx;
  logic [7:0]  class_val, margin;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nn_out_argmax dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_flat(y_flat),
    .busy(busy), .done(done), .class_idx(class_idx),
    .class_val(class_val), .margin(margin)
  );

  typedef struct {
    logic [79:0] y;
    logic [3:0]  idx;
    logic [7:0]  val;
    logic [7:0]  mar;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [79:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    logic [79:0] r;
    r[7:0]   = 8'(a0); r[15:8]  = 8'(a1); r[23:16] = 8'(a2); r[31:24] = 8'(a3);
    r[39:32] = 8'(a4); r[47:40] = 8'(a5); r[55:48] = 8'(a6); r[63:56] = 8'(a7);
    r[71:64] = 8'(a8); r[79:72] = 8'(a9);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        k = c;
        break;
      end
    end
  endtask

  task automatic chk_result(input string name, input vec_t v);
    chk({name, ".idx"}, 32'(class_idx), 32'(v.idx));
    chk({name, ".val"}, 32'(class_val), 32'(v.val));
    chk({name, ".mar"}, 32'(margin), 32'(v.mar));
    chk({name, ".busy_in_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int k;
    y_flat = v.y;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    chk({name, ".busy"}, 32'(busy), 32'd1);
    wait_done(k);
    chk({name, ".lat"}, 32'(k), 32'd10);
    chk_result(name, v);
    @(posedge clk); #1;
    chk({name, ".done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int k;
    int ndone;

    vecs[0] = '{pk(3, -5, 20, 7, 0, 1, 2, 19, -128, 4),                  4'd2, 8'd20,  8'd1};
    vecs[1] = '{pk(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128),
                                                                          4'd0, 8'h80,  8'd0};
    vecs[2] = '{pk(0, 0, 0, 0, 127, 0, 0, 0, 127, 0),                    4'd4, 8'd127, 8'd0};
    vecs[3] = '{pk(127, -128, -128, -128, -128, -128, -128, -128, -128, -128),
                                                                          4'd0, 8'd127, 8'd255};
    vecs[4] = '{pk(-128, -128, -128, -128, -128, -128, -128, -128, -128, 127),
                                                                          4'd9, 8'd127, 8'd255};
    vecs[5] = '{pk(-1, -2, -3, -4, -5, -6, -7, -8, -9, -10),             4'd0, 8'hFF,  8'd1};
    vecs[6] = '{pk(-50, 10, 60, 60, -3, 61, 0, 5, 59, 1),                4'd5, 8'd61,  8'd1};

    rst_n  = 1'b0;
    start  = 1'b0;
    y_flat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.idx",  32'(class_idx), 32'd0);
    chk("rst.val",  32'(class_val), 32'd0);
    chk("rst.mar",  32'(margin), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Busy gating: y_flat change at cycle 2 and start pulse at cycle 4 must be ignored
    y_flat = vecs[0].y;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    ndone  = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == 2) y_flat = vecs[3].y;
      if (c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      if (done) begin
        ndone++;
        chk("gate.lat", 32'(c), 32'd10);
        chk_result("gate", vecs[0]);
      end
    end
    chk("gate.ndone", 32'(ndone), 32'd1);

    // Asynchronous reset mid-scan
    y_flat = vecs[6].y;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.idx",  32'(class_idx), 32'd0);
    chk("mrst.val",  32'(class_val), 32'd0);
    chk("mrst.mar",  32'(margin), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mrst.nodone", 32'(ndone), 32'd0);
    run_vec("post_rst", vecs[2]);

    // Back-to-back with start held high; each result must match its own start-edge snapshot
    y_flat = vecs[4].y;
    start  = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      y_flat = vecs[(j + 5) % 7].y;
      wait_done(k);
      chk($sformatf("b2b%0d.lat", j), 32'(k), 32'd10);
      chk_result($sformatf("b2b%0d", j), vecs[(j + 4) % 7]);
      if (j == 2) start = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.no_dbl", j), 32'(done), 32'd0);
      chk($sformatf("b2b%0d.busy", j), 32'(busy), (j == 2) ? 32'd0 : 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nn_out_argmax.md
# nn_out_argmax

Sequential classifier back-end that consumes the ten 8-bit output-layer neurons of the network top and reduces them to a winning class. On a `start` strobe it snapshots all ten outputs, scans them one per cycle, and reports the index and value of the maximum, plus the margin over the runner-up. The result is a stable, registered decision for the PLL control logic, isolated from the combinational ripple of the network.

## Interface

- `W`, 8: width of each neuron output, signed two's complement.
- `N`, 10: number of neurons. Fixed at 10 for this revision; the index width is 4.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a classification. Sampled only in IDLE.
- `y_flat`  in  N*W: network outputs packed as neuron 1 in bits [W-1:0] through neuron 10 in bits [N*W-1:(N-1)*W]. Must be stable on the `start` edge.
- `busy`  out  1: high while a classification is in progress.
- `done`  out  1: one-cycle pulse when results update.
- `class_idx`  out  4: zero-based index of the winner (neuron 1 → 0, neuron 10 → 9).
- `class_val`  out  W: signed value of the winner.
- `margin`  out  W: unsigned value of winner minus runner-up.

## Operation

- **Reset.** On `rst_n` low, state goes to IDLE immediately. `busy`, `done`, `class_idx`, `class_val` and `margin` are all 0. The snapshot registers are cleared.
- **IDLE.** `start`=1 at a clock edge does the following:
  - captures all ten elements into the snapshot register file;
  - sets best = e[0], second = −2^(W−1), idx = 0, ptr = 1;
  - moves to SCAN.
  - `start` in any other state is ignored. It is not queued.
- **SCAN.** One element e[ptr] is processed per cycle:
  - if e[ptr] > best (strict, signed): second ← best, best ← e[ptr], idx ← ptr;
  - otherwise, if e[ptr] > second: second ← e[ptr];
  - ptr increments. After processing ptr = 9, move to DONE.
- **DONE.** One cycle:
  - register class_idx ← idx, class_val ← best, margin ← best − second;
  - pulse `done`;
  - return to IDLE.
- **Ties.** The strict compare means the lowest index wins. A later element equal to best becomes second, so margin = 0.
- **Margin width.** best − second is evaluated at W+1 bits. It is always in the range 0 to 2^W − 1 and is truncated to W bits with no saturation.
- **Result hold.** Result outputs hold their last value until the next DONE. `y_flat` changes after the `start` edge have no effect.

## Timing

- Edge 0: `start` sampled in IDLE; snapshot taken; `busy`=1 after this edge.
- Edges 1–9: SCAN processes elements 1–9.
- Edge 10: DONE writes the results.
  - `done`=1 and the new results are visible in cycle 10, the cycle after edge 10.
  - `busy`=0 in that same cycle.
- Fixed latency: 10 cycles from the `start` edge to `done`.
- `busy` is high for exactly 10 cycles per request.
- Back-to-back operation:
  - `start` held high during the `done` cycle is accepted at edge 11.
  - The maximum rate is one classification every 11 cycles.
- Reset mid-operation:
  - aborts the scan;
  - no `done` pulse is produced;
  - result outputs go to 0.
- `done` is never high for two consecutive cycles.

## Test plan

1. **Distinct maximum.** y = {3, −5, 20, 7, 0, 1, 2, 19, −128, 4}, start → after 10 cycles: `done`=1, class_idx=2, class_val=20, margin=1.
2. **Tie and all-negative.**
   - All ten = −128 → class_idx=0, class_val=−128, margin=0.
   - y5 = y9 = 127, others 0 → class_idx=4, margin=0.
3. **Extreme margin.** y1=127, others −128 → class_idx=0, margin=255.
   - y10=127, others −128 → class_idx=9, margin=255.
4. **Busy gating and snapshot.**
   - Pulse `start` again at cycle 4 of a scan and change `y_flat` at cycle 2.
   - Required: no restart, results match the edge-0 snapshot, exactly one `done`.
5. **Reset mid-scan.**
   - Assert `rst_n`=0 asynchronously at cycle 5 → outputs read 0 immediately.
   - Release and issue a fresh `start` → correct result 10 cycles later.
6. **Back-to-back.**
   - Hold `start`=1 continuously with changing inputs.
   - Required: `done` every 11 cycles, each result matching the snapshot taken at its own start edge.
